// File: rtl/seg_scan_controller_if.sv
// Display-word update handshake between a value producer and the segment scanner.
interface seg_scan_controller_if;
  logic        upd_valid;
  logic [15:0] upd_data;
  logic        upd_ready;

  modport master (output upd_valid, output upd_data, input upd_ready);
  modport slave  (input upd_valid, input upd_data, output upd_ready);
endinterface

// File: rtl/seg_scan_controller.sv
// Round-robin four-digit seven-segment scanner with blanking guard and
// frame-aligned double-buffered display word.
//
// state    | meaning
// ST_BLANK | all digits off for BLANK_TICKS cycles before each digit slot
// ST_SHOW  | digit idx driven for DIGIT_TICKS cycles (dark if masked/suppressed)
module seg_scan_controller #(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  seg_scan_controller_if.slave      upd_if,
  input  logic [3:0]                digit_mask,
  input  logic                      lz_suppress,
  output logic [6:0]                seg,
  output logic [3:0]                seven_enable,
  output logic                      frame_done
);

  localparam int CNT_MAX  = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CNT_CLOG = $clog2(CNT_MAX);
  localparam int CNT_W    = (CNT_CLOG < 1) ? 1 : CNT_CLOG;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       en_q, en_d;
  logic             frame_done_q, frame_done_d;

  logic             frame_end;
  logic             accept;
  logic             suppressed;
  logic             lit;
  logic [3:0]       nib;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign upd_if.upd_ready = !pend_full_q;
  assign seg              = seg_q;
  assign seven_enable     = en_q;
  assign frame_done       = frame_done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    frame_end   = 1'b0;
    accept      = upd_if.upd_valid && !pend_full_q;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DIGIT_LAST) begin
          state_d   = ST_BLANK;
          cnt_d     = '0;
          idx_d     = idx_q + 2'd1;
          frame_end = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    // Accept and transfer are mutually exclusive: accept needs pend empty.
    if (frame_end && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = upd_if.upd_data;
      pend_full_d = 1'b1;
    end

    frame_done_d = frame_end;

    case (idx_d)
      2'd3:    suppressed = lz_suppress && (disp_d[15:12] == 4'h0);
      2'd2:    suppressed = lz_suppress && (disp_d[15:8]  == 8'h0);
      2'd1:    suppressed = lz_suppress && (disp_d[15:4]  == 12'h0);
      default: suppressed = 1'b0;
    endcase

    nib  = disp_d[{idx_d, 2'b00} +: 4];
    lit  = digit_mask[idx_d] && !suppressed;

    // Outputs are decoded from next state so the registers match the state they accompany.
    seg_d = 7'h7F;
    en_d  = 4'hF;
    if ((state_d == ST_SHOW) && lit) begin
      seg_d = hex_decode(nib);
      en_d  = ~(4'b0001 << idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      disp_q       <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_full_q  <= 1'b0;
      seg_q        <= 7'h7F;
      en_q         <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      seg_q        <= seg_d;
      en_q         <= en_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
